// File: rtl/loop_perf_monitor.sv
// Activity monitor for an HLS block handshake and one pipelined loop inside it.
// Optional stall counter is built only when LOOP_STALL_CNT_EN is defined.
module loop_perf_monitor #(
  parameter int STATE_W = 1,
  parameter int CNT_W   = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               finish,
  input  logic               ap_start,
  input  logic               ap_ready,
  input  logic               ap_done,
  input  logic               ap_continue,
  input  logic [STATE_W-1:0] cur_state,
  input  logic [STATE_W-1:0] iter_start_state,
  input  logic [STATE_W-1:0] iter_end_state,
  input  logic [STATE_W-1:0] quit_state,
  input  logic               iter_start_block,
  input  logic               iter_end_block,
  input  logic               quit_block,
  input  logic               iter_start_enable,
  input  logic               iter_end_enable,
  input  logic               quit_enable,
  input  logic               loop_start,
  input  logic               loop_ready,
  input  logic               loop_done,
  input  logic               loop_continue,
  input  logic               quit_at_end,
  output logic [CNT_W-1:0]   txn_count,
  output logic [CNT_W-1:0]   last_latency,
  output logic               busy,
  output logic [CNT_W-1:0]   iter_count,
  output logic [CNT_W-1:0]   iter_done_count,
  output logic [CNT_W-1:0]   loop_count,
  output logic [CNT_W-1:0]   stall_cycles,
  output logic               loop_active,
  output logic               frozen
);
  typedef enum logic [1:0] {IDLE, RUN, WAIT} state_t;

  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == MAX) ? v : v + ONE;
  endfunction

  // ready strobes are observed only; nothing counts them
  logic unused_ready;
  assign unused_ready = ap_ready ^ loop_ready;

  // nothing advances in the cycle finish is first seen, nor after it
  logic upd;
  assign upd = !frozen && !finish;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  lat, cur_lat;
  logic              complete, lat_load;

  always_ff @(posedge clock) begin
    if (reset)    state <= IDLE;
    else if (upd) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (ap_start) begin
        if (ap_done && ap_continue) state_nxt = IDLE;
        else if (ap_done)           state_nxt = WAIT;
        else                        state_nxt = RUN;
      end
      RUN: begin
        if (ap_done && ap_continue) state_nxt = ap_start ? RUN : IDLE;
        else if (ap_done)           state_nxt = WAIT;
      end
      WAIT: if (ap_continue) state_nxt = ap_start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // lat holds cycles already spent; cur_lat includes the present cycle
  always_comb begin
    complete = 1'b0;
    lat_load = 1'b0;
    cur_lat  = (state == IDLE) ? ONE : sat_inc(lat);
    case (state)
      IDLE: begin
        complete = ap_start && ap_done && ap_continue;
        lat_load = ap_start;
      end
      RUN: begin
        complete = ap_done && ap_continue;
        lat_load = complete && ap_start;
      end
      WAIT: begin
        complete = ap_continue;
        lat_load = complete && ap_start;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lat          <= '0;
      txn_count    <= '0;
      last_latency <= '0;
    end else if (upd) begin
      if (complete) begin
        last_latency <= cur_lat;
        txn_count    <= sat_inc(txn_count);
      end
      if (lat_load)           lat <= ONE;
      else if (state != IDLE) lat <= sat_inc(lat);
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset)       frozen <= 1'b0;
    else if (finish) frozen <= 1'b1;
  end

  // loop start counts as in-flight in its own cycle
  logic in_loop, it_start, it_end, quit_ev, loop_end;
  assign in_loop  = loop_active || loop_start;
  assign it_start = (cur_state == iter_start_state) && !iter_start_block && iter_start_enable && in_loop;
  assign it_end   = (cur_state == iter_end_state) && !iter_end_block && iter_end_enable && in_loop;
  assign quit_ev  = (cur_state == quit_state) && !quit_block && quit_enable && in_loop;
  assign loop_end = in_loop && ((loop_done && loop_continue) || (quit_ev && !quit_at_end));

  always_ff @(posedge clock) begin
    if (reset) begin
      loop_active     <= 1'b0;
      iter_count      <= '0;
      iter_done_count <= '0;
      loop_count      <= '0;
    end else if (upd) begin
      loop_active <= loop_end ? (loop_active && loop_start) : in_loop;
      if (it_start) iter_count      <= sat_inc(iter_count);
      if (it_end)   iter_done_count <= sat_inc(iter_done_count);
      if (loop_end) loop_count      <= sat_inc(loop_count);
    end
  end

`ifdef LOOP_STALL_CNT_EN
  logic [CNT_W-1:0] stall_q;
  always_ff @(posedge clock) begin
    if (reset)
      stall_q <= '0;
    else if (upd && loop_active && (cur_state == iter_start_state) && iter_start_block)
      stall_q <= sat_inc(stall_q);
  end
  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_loop_perf_monitor.sv
// Scoreboard bench for loop_perf_monitor: directed test-plan cases, then
// randomized segments checked against a cycle-indexed reference model.
module tb_loop_perf_monitor;
  localparam int SW = 2;
  localparam int CW = 8;
  localparam int MAXV = (1 << CW) - 1;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset, finish, ap_start, ap_ready, ap_done, ap_continue;
  logic [SW-1:0] cur_state, iss, ies, qs;
  logic isb, ieb, qb, ise, iee, qe;
  logic loop_start, loop_ready, loop_done, loop_continue, quit_at_end;
  logic [CW-1:0] txn_count, last_latency, iter_count, iter_done_count, loop_count, stall_cycles;
  logic busy, loop_active, frozen;

  loop_perf_monitor #(.STATE_W(SW), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .finish(finish),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
    .cur_state(cur_state), .iter_start_state(iss), .iter_end_state(ies), .quit_state(qs),
    .iter_start_block(isb), .iter_end_block(ieb), .quit_block(qb),
    .iter_start_enable(ise), .iter_end_enable(iee), .quit_enable(qe),
    .loop_start(loop_start), .loop_ready(loop_ready), .loop_done(loop_done),
    .loop_continue(loop_continue), .quit_at_end(quit_at_end),
    .txn_count(txn_count), .last_latency(last_latency), .busy(busy),
    .iter_count(iter_count), .iter_done_count(iter_done_count), .loop_count(loop_count),
    .stall_cycles(stall_cycles), .loop_active(loop_active), .frozen(frozen)
  );

  typedef struct {
    logic [31:0] txn, lat, ic, idc, lc, st;
    logic [31:0] busy, la, fr;
  } exp_t;
  exp_t q[$];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: transaction in flight is described by its start cycle
  // and whether it waits for continue; latency is a cycle difference.
  int cyc = 0;
  int ph = 0;          // 0 none, 1 awaiting done, 2 awaiting continue
  int t0 = 0;
  int m_txn, m_lat, m_ic, m_idc, m_lc, m_st;
  bit m_la, m_fr;

  function automatic int sat(input int v);
    return (v >= MAXV) ? MAXV : v + 1;
  endfunction

  function automatic int clip(input int v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  task automatic model_step();
    bit inl, s_ev, e_ev, q_ev, l_end;
    if (reset) begin
      ph = 0; m_txn = 0; m_lat = 0; m_ic = 0; m_idc = 0; m_lc = 0; m_st = 0;
      m_la = 0; m_fr = 0;
    end else if (m_fr) begin
    end else if (finish) begin
      m_fr = 1;
    end else begin
      if (ph == 0) begin
        if (ap_start) begin
          t0 = cyc;
          if (ap_done && ap_continue) begin m_lat = 1; m_txn = sat(m_txn); end
          else ph = ap_done ? 2 : 1;
        end
      end else if ((ph == 1 && ap_done && ap_continue) || (ph == 2 && ap_continue)) begin
        m_lat = clip(cyc - t0 + 1);
        m_txn = sat(m_txn);
        if (ap_start) begin t0 = cyc; ph = 1; end else ph = 0;
      end else if (ph == 1 && ap_done) ph = 2;

      inl  = m_la || loop_start;
      s_ev = inl && cur_state == iss && !isb && ise;
      e_ev = inl && cur_state == ies && !ieb && iee;
      q_ev = inl && cur_state == qs && !qb && qe;
      l_end = inl && ((loop_done && loop_continue) || (q_ev && !quit_at_end));
`ifdef LOOP_STALL_CNT_EN
      if (m_la && cur_state == iss && isb) m_st = sat(m_st);
`endif
      if (s_ev) m_ic = sat(m_ic);
      if (e_ev) m_idc = sat(m_idc);
      if (l_end) m_lc = sat(m_lc);
      m_la = l_end ? (m_la && loop_start) : inl;
    end
    cyc++;
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clock);
    model_step();
    e.txn = m_txn; e.lat = m_lat; e.ic = m_ic; e.idc = m_idc; e.lc = m_lc; e.st = m_st;
    e.busy = (ph != 0); e.la = m_la; e.fr = m_fr;
    q.push_back(e);
    #1;
  endtask

  always @(negedge clock) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("txn_count", txn_count, e.txn);
      chk("last_latency", last_latency, e.lat);
      chk("busy", busy, e.busy);
      chk("iter_count", iter_count, e.ic);
      chk("iter_done_count", iter_done_count, e.idc);
      chk("loop_count", loop_count, e.lc);
      chk("stall_cycles", stall_cycles, e.st);
      chk("loop_active", loop_active, e.la);
      chk("frozen", frozen, e.fr);
    end
  end

  task automatic clr();
    reset = 0; finish = 0; ap_start = 0; ap_ready = 0; ap_done = 0; ap_continue = 0;
    cur_state = 1; iss = 1; ies = 1; qs = 0;
    isb = 0; ieb = 0; qb = 0; ise = 0; iee = 0; qe = 0;
    loop_start = 0; loop_ready = 0; loop_done = 0; loop_continue = 0; quit_at_end = 0;
  endtask

  task automatic do_reset();
    reset = 1; tick(); tick(); reset = 0;
  endtask

  initial begin
    int exp_st;
    clr();
    do_reset();
    @(negedge clock);
    chk("reset_txn", txn_count, 0);
    chk("reset_busy", busy, 0);

    // start at cycle 0, done+continue at cycle 4
    ap_start = 1; tick(); ap_start = 0;
    repeat (3) tick();
    ap_done = 1; ap_continue = 1; tick(); ap_done = 0; ap_continue = 0;
    @(negedge clock);
    chk("tp1_latency", last_latency, 5);
    chk("tp1_txn", txn_count, 1);
    chk("tp1_busy", busy, 0);

    // done at cycle 3, continue held low two cycles
    ap_start = 1; tick(); ap_start = 0;
    tick(); tick();
    ap_done = 1; tick(); ap_done = 0;
    tick();
    @(negedge clock);
    chk("tp2_busy_wait", busy, 1);
    ap_continue = 1; tick(); ap_continue = 0;
    @(negedge clock);
    chk("tp2_latency", last_latency, 6);
    chk("tp2_txn", txn_count, 2);

    // 8-iteration loop, ends lag starts by 10 cycles
    for (int c = 0; c < 18; c++) begin
      loop_start = (c == 0); ise = (c < 8); iee = (c >= 10);
      tick();
    end
    loop_start = 0; ise = 0; iee = 0;
    loop_done = 1; loop_continue = 1; tick(); loop_done = 0; loop_continue = 0;
    @(negedge clock);
    chk("tp3_iter", iter_count, 8);
    chk("tp3_iter_done", iter_done_count, 8);
    chk("tp3_loops", loop_count, 1);
    chk("tp3_stall", stall_cycles, 0);

    // same loop with a 3-cycle start-stage stall
    for (int c = 0; c < 21; c++) begin
      loop_start = (c == 0); isb = (c >= 2 && c <= 4); ise = (c < 11); iee = (c >= 13);
      tick();
    end
    loop_start = 0; isb = 0; ise = 0; iee = 0;
    loop_done = 1; loop_continue = 1; tick(); loop_done = 0; loop_continue = 0;
`ifdef LOOP_STALL_CNT_EN
    exp_st = 3;
`else
    exp_st = 0;
`endif
    @(negedge clock);
    chk("tp4_stall", stall_cycles, exp_st);
    chk("tp4_iter", iter_count, 16);
    chk("tp4_loops", loop_count, 2);

    // finish mid-transaction freezes everything
    ap_start = 1; tick(); ap_start = 0; tick();
    finish = 1; tick(); finish = 0;
    ap_done = 1; ap_continue = 1; repeat (3) tick(); ap_done = 0; ap_continue = 0;
    @(negedge clock);
    chk("tp5_frozen", frozen, 1);
    chk("tp5_txn_held", txn_count, 2);
    chk("tp5_busy_held", busy, 1);

    // reset in RUN with two completed transactions
    do_reset();
    ap_start = 1; ap_done = 1; ap_continue = 1; tick(); tick();
    ap_done = 0; ap_continue = 0; tick(); ap_start = 0; tick();
    @(negedge clock);
    chk("tp6_txn_before", txn_count, 2);
    reset = 1; tick(); reset = 0;
    @(negedge clock);
    chk("tp6_txn_zero", txn_count, 0);
    chk("tp6_busy_zero", busy, 0);
    chk("tp6_lat_zero", last_latency, 0);
    ap_start = 1; tick(); ap_start = 0;
    ap_done = 1; ap_continue = 1; tick(); ap_done = 0; ap_continue = 0;
    @(negedge clock);
    chk("tp6_txn_after", txn_count, 1);
    chk("tp6_lat_after", last_latency, 2);

    // randomized segments; seg 0 saturates loop counters, seg 1 latency
    for (int seg = 0; seg < 6; seg++) begin
      int len, fin_at, p_done;
      clr();
      do_reset();
      iss = SW'($urandom_range(0, 3)); ies = SW'($urandom_range(0, 3)); qs = SW'($urandom_range(0, 3));
      len = (seg == 0) ? 1500 : 400;
      fin_at = (seg % 2 == 1) ? int'($urandom_range(200, 399)) : -1;
      p_done = (seg == 1) ? 2 : 200;
      for (int c = 0; c < len; c++) begin
        ap_start = ($urandom_range(0, 99) < 30);
        ap_done = ($urandom_range(0, 999) < p_done);
        ap_continue = ($urandom_range(0, 99) < 70);
        ap_ready = $urandom_range(0, 1);
        loop_ready = $urandom_range(0, 1);
        cur_state = (seg == 0) ? iss : SW'($urandom_range(0, 3));
        isb = ($urandom_range(0, 99) < ((seg == 0) ? 10 : 25));
        ieb = ($urandom_range(0, 99) < 25);
        qb = ($urandom_range(0, 99) < 25);
        ise = ($urandom_range(0, 99) < 70);
        iee = ($urandom_range(0, 99) < 70);
        qe = ($urandom_range(0, 99) < 10);
        loop_start = ($urandom_range(0, 99) < ((seg == 0) ? 80 : 20));
        loop_done = ($urandom_range(0, 99) < 15);
        loop_continue = ($urandom_range(0, 99) < 70);
        quit_at_end = $urandom_range(0, 1);
        finish = (c == fin_at);
        reset = ($urandom_range(0, 999) < 3);
        tick();
      end
    end
    clr();
    tick();
    repeat (3) @(negedge clock);
    chk("scoreboard_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
